// File: rtl/a23_out_streamer.sv
// Drain stage for a23_gc_main: counts cycles until terminate, snapshots the
// output memory, then streams every word plus a cycle-count trailer over valid/ready.
module a23_out_streamer #(
  parameter int OUT_MEM_SIZE = 64,
  parameter int IDX_W        = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [OUT_MEM_SIZE*32-1:0]   o,
  input  logic                         terminate,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [31:0]                  m_data,
  output logic [IDX_W-1:0]             m_index,
  output logic                         m_last,
  output logic [31:0]                  cycle_count,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_MEM_SIZE);

  state_t             state_q, state_d;
  logic [31:0]        snap_q [OUT_MEM_SIZE];
  logic [31:0]        snap_d [OUT_MEM_SIZE];
  logic [31:0]        cycle_count_q, cycle_count_d;
  logic               m_valid_q, m_valid_d;
  logic [31:0]        m_data_q, m_data_d;
  logic [IDX_W-1:0]   m_index_q, m_index_d;
  logic               m_last_q, m_last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [IDX_W-1:0]   nxt_idx;
  logic [31:0]        nxt_word;

  always_comb begin
    state_d       = state_q;
    snap_d        = snap_q;
    cycle_count_d = cycle_count_q;
    m_valid_d     = m_valid_q;
    m_data_d      = m_data_q;
    m_index_d     = m_index_q;
    m_last_d      = m_last_q;
    busy_d        = busy_q;
    done_d        = done_q;

    // m_index doubles as the word pointer; past the last snapshot word the
    // next word is the frozen cycle count.
    nxt_idx  = m_index_q + 1'b1;
    nxt_word = cycle_count_q;
    for (int i = 0; i < OUT_MEM_SIZE; i++) begin
      if (nxt_idx == IDX_W'(i)) nxt_word = snap_q[i];
    end

    case (state_q)
      S_RUN: begin
        if (terminate) begin
          for (int i = 0; i < OUT_MEM_SIZE; i++) snap_d[i] = o[32*i +: 32];
          state_d   = S_STREAM;
          m_valid_d = 1'b1;
          busy_d    = 1'b1;
          m_data_d  = o[31:0];
          m_index_d = '0;
          m_last_d  = 1'b0;
        end else if (cycle_count_q != 32'hFFFF_FFFF) begin
          cycle_count_d = cycle_count_q + 32'd1;
        end
      end
      S_STREAM: begin
        if (m_ready) begin
          if (m_last_q) begin
            state_d   = S_DONE;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            m_index_d = nxt_idx;
            m_data_d  = nxt_word;
            m_last_d  = (nxt_idx == LAST_IDX);
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_RUN;
      for (int i = 0; i < OUT_MEM_SIZE; i++) snap_q[i] <= '0;
      cycle_count_q <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_index_q     <= '0;
      m_last_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      snap_q        <= snap_d;
      cycle_count_q <= cycle_count_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_index_q     <= m_index_d;
      m_last_q      <= m_last_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_index     = m_index_q;
  assign m_last      = m_last_q;
  assign cycle_count = cycle_count_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_a23_out_streamer.sv
// Bench for a23_out_streamer: vector table, directed stream scenarios and
// randomized traffic, all checked every cycle against a queue-based model.
module tb_a23_out_streamer;

  localparam int N  = 64;
  localparam int IW = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*32-1:0]   o;
  logic              terminate;
  logic              m_valid;
  logic              m_ready;
  logic [31:0]       m_data;
  logic [IW-1:0]     m_index;
  logic              m_last;
  logic [31:0]       cycle_count;
  logic              busy;
  logic              done;

  a23_out_streamer #(.OUT_MEM_SIZE(N), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .o(o), .terminate(terminate),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
    .m_last(m_last), .cycle_count(cycle_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a run counter plus a queue of words still to be sent.
  logic [31:0] mdl_cnt;
  bit          mdl_stream, mdl_done;
  logic [31:0] mdl_q [$];
  logic [31:0] mdl_data;
  int          mdl_index;

  typedef struct {
    logic [31:0] d;
    int          idx;
    logic        last;
  } rx_t;
  rx_t rx [$];

  typedef struct {
    logic        rst, term, rdy;
    logic        v, busy, done, last;
    int          idx;
    logic [31:0] data, cnt;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (!rst) begin
      mdl_cnt = 0; mdl_stream = 0; mdl_done = 0; mdl_q.delete();
      mdl_data = 0; mdl_index = 0;
    end else if (!mdl_stream && !mdl_done) begin
      if (terminate) begin
        for (int i = 0; i < N; i++) mdl_q.push_back(o[32*i +: 32]);
        mdl_q.push_back(mdl_cnt);
        mdl_stream = 1; mdl_data = mdl_q[0]; mdl_index = 0;
      end else if (mdl_cnt != 32'hFFFF_FFFF) begin
        mdl_cnt = mdl_cnt + 1;
      end
    end else if (mdl_stream && m_ready) begin
      void'(mdl_q.pop_front());
      if (mdl_q.size() == 0) begin
        mdl_stream = 0; mdl_done = 1;
      end else begin
        mdl_data = mdl_q[0]; mdl_index = N + 1 - mdl_q.size();
      end
    end
  endtask

  task automatic tick(input bit check_model);
    rx_t r;
    if (m_valid === 1'b1 && m_ready && rst) begin
      r.d = m_data; r.idx = int'(m_index); r.last = m_last;
      rx.push_back(r);
    end
    @(posedge clk);
    model_edge();
    #1;
    if (check_model) begin
      chk("m_valid", 32'(m_valid), 32'(mdl_stream));
      chk("busy", 32'(busy), 32'(mdl_stream));
      chk("done", 32'(done), 32'(mdl_done));
      chk("m_last", 32'(m_last), 32'(mdl_stream && mdl_q.size() == 1));
      chk("m_data", m_data, mdl_data);
      chk("m_index", 32'(m_index), 32'(mdl_index));
      chk("cycle_count", cycle_count, mdl_cnt);
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < N; i++) o[32*i +: 32] = 32'hA500_0000 + 32'(i);
  endtask

  task automatic do_reset();
    rst = 1'b0; terminate = 1'b0; m_ready = 1'b0;
    tick(1);
    rst = 1'b1;
  endtask

  task automatic idle(input int n);
    terminate = 1'b0;
    for (int i = 0; i < n; i++) tick(1);
  endtask

  task automatic fire();
    rx.delete();
    terminate = 1'b1;
    tick(1);
    chk("start_valid", 32'(m_valid), 32'd1);
    chk("start_index", 32'(m_index), 32'd0);
  endtask

  task automatic drain(input int mode, input bit toggle_term, output int iters);
    iters = 0;
    while (done !== 1'b1 && iters < 1000) begin
      m_ready   = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      terminate = toggle_term ? iters[1] : 1'b0;
      tick(1);
      iters++;
    end
    chk("drain_done", 32'(done), 32'd1);
  endtask

  task automatic verify_rx(input logic [31:0] trailer);
    logic [31:0] exp;
    chk("rx_count", 32'(rx.size()), 32'(N + 1));
    for (int i = 0; i < rx.size() && i <= N; i++) begin
      exp = (i < N) ? 32'hA500_0000 + 32'(i) : trailer;
      chk("rx_data", rx[i].d, exp);
      chk("rx_index", 32'(rx[i].idx), 32'(i));
      chk("rx_last", 32'(rx[i].last), 32'(i == N));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int iters;
    int rst_at;

    //            rst  term rdy  v    busy done last idx data            cnt
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,0, 32'h0,          32'd0};
    tbl[1]  = '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,0, 32'hA500_0000,  32'd0};
    tbl[2]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,0, 32'hA500_0000,  32'd0};
    tbl[3]  = '{1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1, 32'hA500_0001,  32'd0};
    tbl[4]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,2, 32'hA500_0002,  32'd0};
    tbl[5]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2, 32'hA500_0002,  32'd0};
    tbl[6]  = '{1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,3, 32'hA500_0003,  32'd0};
    tbl[7]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,0, 32'h0,          32'd0};
    tbl[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,0, 32'h0,          32'd1};
    tbl[9]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,0, 32'h0,          32'd2};
    tbl[10] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,0, 32'hA500_0000,  32'd2};
    tbl[11] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,0, 32'h0,          32'd0};
    tbl[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,0, 32'h0,          32'd1};

    rst = 1'b0; terminate = 1'b0; m_ready = 1'b0;
    fill_pattern();
    for (int k = 0; k < 13; k++) begin
      rst = tbl[k].rst; terminate = tbl[k].term; m_ready = tbl[k].rdy;
      tick(1);
      chk("tbl_valid", 32'(m_valid), 32'(tbl[k].v));
      chk("tbl_busy", 32'(busy), 32'(tbl[k].busy));
      chk("tbl_done", 32'(done), 32'(tbl[k].done));
      chk("tbl_last", 32'(m_last), 32'(tbl[k].last));
      chk("tbl_index", 32'(m_index), 32'(tbl[k].idx));
      chk("tbl_data", m_data, tbl[k].data);
      chk("tbl_count", cycle_count, tbl[k].cnt);
    end

    // Immediate terminate: trailer reports zero cycles.
    do_reset(); fire(); drain(0, 0, iters);
    verify_rx(32'd0);

    // Free-running ready: 65 transfers on 65 consecutive cycles.
    do_reset(); idle(100); fire(); drain(0, 0, iters);
    chk("free_cycles", 32'(iters), 32'(N + 1));
    chk("after_valid", 32'(m_valid), 32'd0);
    verify_rx(32'd100);

    // Backpressure with random ready.
    do_reset(); idle(100); fire(); drain(1, 0, iters);
    verify_rx(32'd100);

    // Snapshot isolation: overwrite o and toggle terminate after the snapshot.
    do_reset(); idle(100); fire();
    for (int i = 0; i < N; i++) o[32*i +: 32] = 32'hFFFF_FFFF;
    drain(1, 1, iters);
    for (int i = 0; i < 10; i++) begin terminate = 1'(i % 2); tick(1); end
    chk("iso_done", 32'(done), 32'd1);
    verify_rx(32'd100);
    fill_pattern();

    // Reset after the 10th transfer, then a fresh stream after 5 idle cycles.
    do_reset(); idle(20); fire();
    m_ready = 1'b1; terminate = 1'b0;
    for (int i = 0; i < 100 && rx.size() < 10; i++) tick(1);
    chk("mid_rx", 32'(rx.size()), 32'd10);
    rst = 1'b0; tick(1);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_index", 32'(m_index), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_count", cycle_count, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b1; idle(5); fire(); drain(0, 0, iters);
    verify_rx(32'd5);

    // Saturation: preload the counter just below the top.
    do_reset(); idle(3);
    force dut.cycle_count_q = 32'hFFFF_FFFD;
    mdl_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.cycle_count_q;
    idle(4);
    chk("sat_count", cycle_count, 32'hFFFF_FFFF);
    fire(); drain(0, 0, iters);
    verify_rx(32'hFFFF_FFFF);

    // Randomized traffic with occasional mid-stream resets.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) o[32*i +: 32] = $urandom();
      do_reset(); idle($urandom_range(0, 40)); fire();
      rst_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 70) : -1;
      for (int c = 0; c < 300 && done !== 1'b1; c++) begin
        m_ready   = 1'($urandom_range(0, 1));
        terminate = 1'($urandom_range(0, 1));
        rst       = (c == rst_at) ? 1'b0 : 1'b1;
        if (c % 7 == 3) o[31:0] = $urandom();
        tick(1);
      end
      rst = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/a23_out_streamer.md
# a23_out_streamer

Downstream drain stage for `a23_gc_main`. While the core runs, it counts clock cycles. When `terminate` is first seen, it snapshots the flat `o` output memory. It then streams the words out in index order over a valid/ready interface, followed by one trailer word holding the cycle count. This replaces the bench-side `$writememh` dump in synthesised and emulated flows.

## Interface
- `OUT_MEM_SIZE`, 64: number of 32-bit output words; must match the core's `OUT_MEM_SIZE`, minimum 1.
- `IDX_W`, 7: width of `m_index`; must satisfy 2^IDX_W > OUT_MEM_SIZE.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `o`  in  OUT_MEM_SIZE*32  flat output memory from the core; word i is `o[32*i+31:32*i]`.
- `terminate`  in  1  core finished; level, sampled each cycle.
- `m_valid`  out  1  stream word available.
- `m_ready`  in  1  downstream accepts; a transfer is a cycle with `m_valid & m_ready`.
- `m_data`  out  32  stream word.
- `m_index`  out  IDX_W  index of the current word; OUT_MEM_SIZE on the trailer.
- `m_last`  out  1  high only on the trailer word.
- `cycle_count`  out  32  live cycle counter; frozen once `terminate` is seen.
- `busy`  out  1  high while in STREAM.
- `done`  out  1  high after the trailer has been accepted.

## Operation
- States: RUN, STREAM, DONE. Reset (`rst`=0 at an edge) forces RUN from any state.
- Reset values:
  - `m_valid`, `m_last`, `busy`, `done`: 0.
  - `m_data`, `m_index`, `cycle_count`: 0.
  - Snapshot register: all zero.
- RUN:
  - Each cycle with `terminate`=0, `cycle_count` increments by 1, saturating at 0xFFFFFFFF.
  - On a cycle with `terminate`=1:
    - no increment;
    - all of `o` is copied into the snapshot register;
    - go to STREAM.
- STREAM:
  - Word pointer p starts at 0.
  - `m_valid`=1 and `busy`=1 throughout.
  - `m_data` = snapshot word p for p < OUT_MEM_SIZE; for p = OUT_MEM_SIZE it is the frozen `cycle_count`.
  - `m_index`=p; `m_last`=(p==OUT_MEM_SIZE).
  - On a transfer:
    - if p < OUT_MEM_SIZE, p increments;
    - if p == OUT_MEM_SIZE, go to DONE.
- DONE:
  - `m_valid`=0, `m_last`=0, `busy`=0, `done`=1.
  - `m_data` and `m_index` hold their last values.
  - Stays in DONE until reset.
- Inputs ignored after the snapshot:
  - `o` changes and `terminate` falling or toggling are ignored in STREAM and DONE.
  - `m_ready` is ignored when `m_valid`=0.
- Arithmetic:
  - `cycle_count` is unsigned 32-bit and never wraps.
  - p is unsigned; its range is 0..OUT_MEM_SIZE.

## Timing
- Registered outputs throughout; there is no combinational path from any input to any output.
- Cycle counting: if `rst` deasserts at edge E0 and `terminate` is first high at edge En, then `cycle_count`=n-1 from the edge after En onward. `terminate` already high at the first post-reset edge gives `cycle_count`=0.
- Latency:
  - `m_valid` rises on the edge after `terminate` is sampled high, carrying word 0 (1-cycle latency).
  - The snapshot is taken on that same edge, so it holds the `o` value present in the `terminate` cycle.
- Handshake:
  - Once `m_valid`=1, `m_data`, `m_index` and `m_last` are stable until the transfer completes.
  - `m_valid` does not drop before the trailer has been transferred.
  - With `m_ready` held at 1, one word transfers per cycle: OUT_MEM_SIZE+1 transfers, and `done`=1 on the edge after the trailer transfer.
- Back-to-back: after a transfer, the next word appears on the following edge with `m_valid` continuously high (no bubble).
- Reset during STREAM or DONE: the next edge restores all reset values, and counting restarts from 0 in RUN.
- Simultaneous `rst`=0 and `terminate`=1: reset wins and no snapshot is taken.

## Test plan
- Free-running ready:
  - Stimulus: OUT_MEM_SIZE=64, `o` word i = 0xA5000000+i, `terminate` rises 100 cycles after reset, `m_ready`=1.
  - Required: 65 transfers in 65 consecutive cycles; data 0xA5000000..0xA500003F at indices 0..63; trailer at index 64 with `m_last`=1 and data 100; then `done`=1 and `m_valid`=0.
- Backpressure:
  - Stimulus: `m_ready` toggles 1,0,0,1,... pseudo-randomly.
  - Required: data and index stable while stalled; the received sequence is identical to the free-running case, with no drops or duplicates.
- Snapshot isolation:
  - Stimulus: after `terminate`, drive `o` to all 0xFFFFFFFF and pulse `terminate` low then high.
  - Required: the streamed words are still the pre-`terminate` values, and only one stream is produced.
- Immediate terminate:
  - Stimulus: `terminate`=1 already at the first post-reset edge.
  - Required: trailer data = 0, and word 0 is valid one cycle later.
- Reset mid-stream:
  - Stimulus: assert `rst`=0 for 1 cycle after the 10th transfer, then run `terminate` again after 5 cycles.
  - Required: all outputs return to 0 on the reset edge; the new stream restarts at index 0 with trailer data = 5.
- Saturation:
  - Stimulus: force `cycle_count` near 0xFFFFFFFE and hold `terminate`=0 for 4 more cycles.
  - Required: counter reads 0xFFFFFFFF and the trailer reports 0xFFFFFFFF.
